// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: widths, fetch FSM states, IF/ID payload and base opcodes.
package rv32i_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned OPCODE_W = 7;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [OPCODE_W-1:0] OPC_LUI      = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OPC_JAL      = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OPC_JALR     = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPC_LOAD     = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_STORE    = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_OP       = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [OPCODE_W-1:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clear kills the entry, load captures a new one, otherwise hold.
module if_id_reg
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] instr
);

    if_id_t q;

    // pc+4 is registered alongside pc so decode sees it without an adder in its path
    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            q        <= '{pc: RESET_PC, instr: NOP_INSTR};
            pc_plus4 <= RESET_PC + XLEN'(4);
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            q        <= '{pc: load_pc, instr: load_instr};
            pc_plus4 <= load_pc + XLEN'(4);
        end
    end

    assign pc    = q.pc;
    assign instr = q.instr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem req/ack handshake, skid for stalled returns, IF/ID.
module fetch_unit
    import rv32i_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [XLEN-1:0]     imem_rdata,
    output logic                if_valid,
    output logic [XLEN-1:0]     if_pc,
    output logic [XLEN-1:0]     if_pc_plus4,
    output logic [XLEN-1:0]     if_instr,
    output logic [OPCODE_W-1:0] if_opcode
);

    fetch_state_e    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] req_addr, req_addr_next;
    if_id_t          skid, skid_next;
    if_id_t          id_d;
    logic            id_load, id_clear;
    logic [XLEN-1:0] redirect_aligned;

    assign redirect_aligned = redirect_pc & ~XLEN'(3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            skid     <= '{pc: RESET_PC, instr: NOP_INSTR};
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            req_addr <= req_addr_next;
            skid     <= skid_next;
        end
    end

    // Flush takes priority in every state; WAIT/DISCARD keep the request stable until acked
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_addr_next = req_addr;
        skid_next     = skid;
        id_d          = '{pc: pc, instr: imem_rdata};
        id_load       = 1'b0;
        id_clear      = 1'b0;
        imem_req      = 1'b0;
        imem_addr     = pc;

        case (state)
            RUN: begin
                imem_req = !stall && !flush;
                if (flush) begin
                    id_clear = 1'b1;
                    pc_next  = redirect_aligned;
                end else if (imem_req && imem_ack) begin
                    id_load = 1'b1;
                    pc_next = pc + XLEN'(4);
                end else if (imem_req) begin
                    id_clear      = 1'b1;
                    req_addr_next = pc;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                imem_req  = 1'b1;
                imem_addr = req_addr;
                if (flush) begin
                    id_clear   = 1'b1;
                    pc_next    = redirect_aligned;
                    state_next = imem_ack ? RUN : DISCARD;
                end else if (imem_ack && !stall) begin
                    id_d       = '{pc: req_addr, instr: imem_rdata};
                    id_load    = 1'b1;
                    pc_next    = req_addr + XLEN'(4);
                    state_next = RUN;
                end else if (imem_ack) begin
                    skid_next  = '{pc: req_addr, instr: imem_rdata};
                    state_next = HOLD;
                end else if (!stall) begin
                    id_clear = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    id_clear   = 1'b1;
                    pc_next    = redirect_aligned;
                    state_next = RUN;
                end else if (!stall) begin
                    id_d       = skid;
                    id_load    = 1'b1;
                    pc_next    = skid.pc + XLEN'(4);
                    state_next = RUN;
                end
            end
            DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = req_addr;
                if (flush) begin
                    id_clear = 1'b1;
                    pc_next  = redirect_aligned;
                end
                if (imem_ack) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase

        if (rst) begin
            imem_req = 1'b0;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (id_load),
        .clear      (id_clear),
        .load_pc    (id_d.pc),
        .load_instr (id_d.instr),
        .valid      (if_valid),
        .pc         (if_pc),
        .pc_plus4   (if_pc_plus4),
        .instr      (if_instr)
    );

    assign if_opcode = if_instr[OPCODE_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus reset-mid-request sequence.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic [6:0]  if_opcode;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // Memory returns address-tagged data so dropped or duplicated fetches are visible
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[24:0], 7'h33};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .if_instr    (if_instr),
        .if_opcode   (if_opcode)
    );

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic [31:0] redir;
        logic        ack;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic fl, input logic [31:0] rd, input logic ak,
                       input logic ereq, input logic [31:0] eaddr, input logic ev,
                       input logic [31:0] epc);
        vec_t v;
        v.stall = st; v.flush = fl; v.redir = rd; v.ack = ak;
        v.ereq = ereq; v.eaddr = eaddr; v.evalid = ev; v.epc = epc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic [31:0] epc);
        chk({tag, " if_pc"}, if_pc, epc);
        chk({tag, " if_instr"}, if_instr, mem_word(epc));
        chk({tag, " if_pc_plus4"}, if_pc_plus4, epc + 32'd4);
        chk({tag, " if_opcode"}, 32'(if_opcode), 32'h33);
    endtask

    initial begin
        bit got;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0; imem_ack = 1'b0;

        // stall flush redir        ack  req addr          valid pc
        add(0, 0, 32'h0,         1,   1, 32'h0,         0, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h4,         1, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h8,         1, 32'h4);
        add(0, 0, 32'h0,         1,   1, 32'hC,         1, 32'h8);
        add(0, 0, 32'h0,         0,   1, 32'h10,        1, 32'hC);
        add(0, 0, 32'h0,         0,   1, 32'h10,        0, 32'h0);
        add(0, 0, 32'h0,         0,   1, 32'h10,        0, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h10,        0, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h14,        1, 32'h10);
        add(0, 0, 32'h0,         0,   1, 32'h18,        1, 32'h14);
        add(1, 0, 32'h0,         1,   1, 32'h18,        0, 32'h0);
        add(1, 0, 32'h0,         0,   0, 32'h0,         0, 32'h0);
        add(0, 0, 32'h0,         0,   0, 32'h0,         0, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h1C,        1, 32'h18);
        add(1, 0, 32'h0,         1,   0, 32'h0,         1, 32'h1C);
        add(1, 0, 32'h0,         1,   0, 32'h0,         1, 32'h1C);
        add(0, 0, 32'h0,         1,   1, 32'h20,        1, 32'h1C);
        add(0, 0, 32'h0,         0,   1, 32'h24,        1, 32'h20);
        add(0, 1, 32'h200,       0,   1, 32'h24,        0, 32'h0);
        add(0, 0, 32'h0,         0,   1, 32'h24,        0, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h24,        0, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h200,       0, 32'h0);
        add(0, 0, 32'h0,         0,   1, 32'h204,       1, 32'h200);
        add(0, 0, 32'h0,         1,   1, 32'h204,       0, 32'h0);
        add(1, 1, 32'h103,       1,   0, 32'h0,         1, 32'h204);
        add(0, 0, 32'h0,         1,   1, 32'h100,       0, 32'h0);
        add(0, 1, 32'hFFFF_FFFC, 1,   0, 32'h0,         1, 32'h100);
        add(0, 0, 32'h0,         1,   1, 32'hFFFF_FFFC, 0, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h0,         1, 32'hFFFF_FFFC);
        add(0, 0, 32'h0,         0,   1, 32'h4,         1, 32'h0);
        add(0, 1, 32'h300,       1,   1, 32'h4,         0, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h300,       0, 32'h0);
        add(0, 0, 32'h0,         0,   1, 32'h304,       1, 32'h300);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset imem_req", 32'(imem_req), 32'h0);
        chk("reset if_valid", 32'(if_valid), 32'h0);
        chk("reset if_pc", if_pc, 32'h0);
        chk("reset if_instr", if_instr, 32'h13);
        chk("reset if_opcode", 32'(if_opcode), 32'h13);
        chk("reset if_pc_plus4", if_pc_plus4, 32'h4);
        rst = 1'b0;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            stall = vecs[i].stall; flush = vecs[i].flush;
            redirect_pc = vecs[i].redir; imem_ack = vecs[i].ack;
            #1;
            chk({tag, " imem_req"}, 32'(imem_req), 32'(vecs[i].ereq));
            if (vecs[i].ereq) chk({tag, " imem_addr"}, imem_addr, vecs[i].eaddr);
            chk({tag, " if_valid"}, 32'(if_valid), 32'(vecs[i].evalid));
            if (vecs[i].evalid) chk_id(tag, vecs[i].epc);
            @(posedge clk);
            @(negedge clk);
        end

        // Reset while a request is outstanding (DUT is in WAIT on 0x304)
        stall = 1'b0; flush = 1'b0; imem_ack = 1'b0; rst = 1'b1;
        #1;
        chk("rst mid-request imem_req", 32'(imem_req), 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst mid-request if_valid", 32'(if_valid), 32'h0);
        chk("rst mid-request if_instr", if_instr, 32'h13);
        rst = 1'b0; imem_ack = 1'b1;
        #1;
        chk("post-reset imem_req", 32'(imem_req), 32'h1);
        chk("post-reset imem_addr", imem_addr, 32'h0);
        got = 1'b0;
        for (int c = 0; c < 4 && !got; c++) begin
            @(posedge clk);
            #1;
            got = if_valid;
        end
        chk("post-reset if_valid within budget", 32'(got), 32'h1);
        if (got) chk_id("post-reset", 32'h0);
        imem_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
